image_store: RTL and testbench
==============================

// Module: image_store
// PURPOSE
//  Image memory responder for the pixel-processing FSM. It answers the FSM's row/col read
//  requests with in_pix and absorbs its out_we/out_pix writes.
//  Uses two 64x64x24 banks in ping-pong: each stage reads one bank and writes the other.
//  A valid/ready stream loads the source image; after the last stage a second stream dumps
//  the result. Sits between the testbench/DMA side and the processing FSM.
// PARAMETERS
//  STAGES  3  number of stage-done events (mirror, gray, filter) before DUMP starts
// PORTS
//  clk          in   1   clock
//  rst_n        in   1   asynchronous reset, active low
//  ld_valid     in   1   load pixel valid
//  ld_pix       in   24  load pixel, raster order: row-major, col fastest (R 23:16, G 15:8, B 7:0)
//  ld_ready     out  1   load pixel accepted when ld_valid && ld_ready
//  proc_start   out  1   1-cycle pulse: image loaded, processing may begin
//  row          in   6   FSM read/write row
//  col          in   6   FSM read/write column
//  in_pix       out  24  read-bank pixel at [row,col]
//  out_we       in   1   FSM write enable
//  out_pix      in   24  FSM write data
//  mirror_done  in   1   stage-done level from FSM
//  gray_done    in   1   stage-done level from FSM
//  filter_done  in   1   stage-done level from FSM
//  dump_valid   out  1   result pixel valid
//  dump_ready   in   1   sink ready
//  dump_pix     out  24  result pixel
//  dump_last    out  1   high with pixel [63,63]
//  busy         out  1   high in any state but DUMP_END
// BEHAVIOUR
//  States
//   LOAD -> SERVE  after 4096th ld handshake
//   SERVE -> DUMP  on STAGES-th stage event
//   DUMP -> DUMP_END  on handshake with dump_last
//   DUMP_END -> LOAD  on ld_valid
//  Reset (async, rst_n=0): state=LOAD, ld_cnt=0, stage_cnt=0, dump_cnt=0, bank_sel=0,
//   done edge registers=0, proc_start=0, dump_valid=0, dump_last=0, busy=1,
//   ld_ready=1 after release. Memory contents are not cleared.
//   Reset mid-operation aborts the current job; no partial dump is resumed.
//  LOAD
//   ld_ready=1.
//   Each handshake writes bank[bank_sel] at ld_cnt (row=ld_cnt[11:6], col=ld_cnt[5:0]), ld_cnt++.
//   On cnt 4095 accepted: next cycle SERVE, proc_start=1 for exactly that one cycle.
//  SERVE
//   in_pix = bank[bank_sel][row][col]: combinational, zero-latency, so the FSM samples it in
//    the same cycle it drives row/col.
//   out_we=1 at posedge writes out_pix to bank[~bank_sel][row][col].
//   out_we is ignored in every other state. ld_ready=0.
//  Stage events
//   Rising edge of any done input, detected against registered copies.
//   Done inputs may stay high indefinitely; only 0->1 counts.
//   Simultaneous rising edges on several inputs count as one event.
//   Event in SERVE: bank_sel toggles and stage_cnt++, effective next cycle.
//   A write in the same cycle as the event lands in the pre-toggle write bank.
//   Events outside SERVE are ignored; edge registers still track.
//   When stage_cnt reaches STAGES: go to DUMP, dump_cnt=0.
//   The result is then in bank[bank_sel] after the final toggle.
//  DUMP
//   dump_valid=1; dump_pix = bank[bank_sel][dump_cnt]; dump_last = (dump_cnt==4095).
//   On handshake dump_cnt++.
//   While dump_valid && !dump_ready: dump_pix and dump_last hold stable.
//   Handshake with dump_last -> DUMP_END; dump_valid=0 the next cycle.
//  DUMP_END
//   busy=0, ld_ready=1.
//   First ld handshake is accepted as pixel 0 of a new load: state LOAD, ld_cnt=1,
//    stage_cnt=0, bank_sel unchanged.
//  Counters
//   ld_cnt and dump_cnt are 12 bits and wrap only through state exit; no overflow past 4095.
// CONFIGURATION
//  STORE_CHECKSUM_EN
//   Defined: adds output port dump_sum [31:0], reset 0 and cleared on LOAD entry.
//    On each dump handshake: dump_sum <= dump_sum + {8'b0, dump_pix}, unsigned, mod 2^32.
//    Holds its value through DUMP_END.
//   Undefined: port and adder are absent; all other behaviour is identical.
// TESTING
//  1. Load 4096 pixels, value = {row,col,12'h0}, ld_valid always 1
//     -> ld_ready never drops in LOAD; proc_start single pulse 1 cycle after last accept.
//  2. SERVE, bank_sel=0, row=5 col=9
//     -> in_pix=24'h149000 same cycle; out_we=1 with out_pix=24'hABCDEF writes bank1[5][9]
//        only; bank0[5][9] is unchanged.
//  3. mirror_done held high 100 cycles, then gray_done rises, then filter_done rises
//     -> stage_cnt steps 1,2,3 (one step per rising edge); DUMP entered after filter edge.
//  4. Dump with dump_ready toggling 1,0,0,1
//     -> dump_pix held while stalled; exactly 4096 handshakes; dump_last only on the 4096th;
//        busy=0 afterwards.
//  5. rst_n=0 asynchronously at ld_cnt=2000
//     -> outputs reset immediately without a clock edge; a fresh load of 4096 pixels is
//        needed for proc_start.
//  6. With STORE_CHECKSUM_EN, all pixels 24'h000001 -> dump_sum=32'd4096 at DUMP_END.

Source files
------------

// File: rtl/image_store.sv
// image_store: ping-pong image memory between a load stream, the pixel
// processing FSM and a dump stream. Two 64x64x24 banks share one array,
// addressed as {bank, row, col}. The processing FSM reads bank[bank_sel] and
// writes bank[~bank_sel]. Each stage-done rising edge swaps the banks.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// A producer holds valid and its data stable until that edge.
//
// Optional feature: define STORE_CHECKSUM_EN to add the dump_sum output.
// dump_sum is a running 32-bit sum of the dumped pixels.
module image_store #(
  parameter int STAGES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_valid,
  input  logic [23:0] ld_pix,
  output logic        ld_ready,
  output logic        proc_start,
  input  logic [5:0]  row,
  input  logic [5:0]  col,
  output logic [23:0] in_pix,
  input  logic        out_we,
  input  logic [23:0] out_pix,
  input  logic        mirror_done,
  input  logic        gray_done,
  input  logic        filter_done,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [23:0] dump_pix,
  output logic        dump_last,
  output logic        busy,
`ifdef STORE_CHECKSUM_EN
  output logic [31:0] dump_sum,
`endif
  output logic [1:0]  dbg_state
);

  localparam int SW = (STAGES < 2) ? 1 : $clog2(STAGES + 1);

  typedef enum logic [1:0] {
    ST_LOAD     = 2'd0,
    ST_SERVE    = 2'd1,
    ST_DUMP     = 2'd2,
    ST_DUMP_END = 2'd3
  } state_t;

  state_t          state;
  logic [11:0]     ld_cnt;
  logic [11:0]     dump_cnt;
  logic [SW-1:0]   stage_cnt;
  logic            bank_sel;
  logic [2:0]      done_q;
  logic [2:0]      done_now;
  logic            stage_evt;
  logic            ld_fire;
  logic            dump_fire;

  logic [23:0]     mem [0:8191];
  logic            mem_we;
  logic [12:0]     mem_waddr;
  logic [23:0]     mem_wdata;

  assign done_now   = {filter_done, gray_done, mirror_done};
  // Any 0->1 transition on any done line, several at once still one event.
  assign stage_evt  = |(done_now & ~done_q);

  assign ld_ready   = (state == ST_LOAD) || (state == ST_DUMP_END);
  assign ld_fire    = ld_valid && ld_ready;
  assign dump_fire  = dump_valid && dump_ready;
  assign busy       = (state != ST_DUMP_END);
  assign dbg_state  = state;

  // Zero-latency reads: the FSM samples in_pix in the cycle it drives row/col.
  assign in_pix     = mem[{bank_sel, row, col}];
  assign dump_pix   = mem[{bank_sel, dump_cnt}];
  assign dump_last  = dump_valid && (dump_cnt == 12'd4095);

  // Select the single memory write: load stream, or FSM write in SERVE.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = {~bank_sel, row, col};
    mem_wdata = out_pix;
    if (ld_fire) begin
      mem_we    = 1'b1;
      mem_waddr = {bank_sel, ld_cnt};
      mem_wdata = ld_pix;
    end else if ((state == ST_SERVE) && out_we) begin
      mem_we    = 1'b1;
    end
  end

  // Image storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Control FSM with its counters, bank select and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_LOAD;
      ld_cnt     <= '0;
      dump_cnt   <= '0;
      stage_cnt  <= '0;
      bank_sel   <= 1'b0;
      done_q     <= '0;
      proc_start <= 1'b0;
      dump_valid <= 1'b0;
    end else begin
      done_q     <= done_now;
      proc_start <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (ld_fire) begin
            if (ld_cnt == 12'd4095) begin
              state      <= ST_SERVE;
              ld_cnt     <= '0;
              proc_start <= 1'b1;
            end else begin
              ld_cnt <= ld_cnt + 12'd1;
            end
          end
        end
        ST_SERVE: begin
          if (stage_evt) begin
            bank_sel  <= ~bank_sel;
            stage_cnt <= stage_cnt + 1'b1;
            if (stage_cnt == SW'(STAGES - 1)) begin
              state      <= ST_DUMP;
              dump_cnt   <= '0;
              dump_valid <= 1'b1;
            end
          end
        end
        ST_DUMP: begin
          if (dump_fire) begin
            if (dump_cnt == 12'd4095) begin
              state      <= ST_DUMP_END;
              dump_cnt   <= '0;
              dump_valid <= 1'b0;
            end else begin
              dump_cnt <= dump_cnt + 12'd1;
            end
          end
        end
        ST_DUMP_END: begin
          // The accepted pixel is pixel 0 of the next image.
          if (ld_fire) begin
            state     <= ST_LOAD;
            ld_cnt    <= 12'd1;
            stage_cnt <= '0;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

`ifdef STORE_CHECKSUM_EN
  // Running sum of dumped pixels, cleared when a new load begins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dump_sum <= '0;
    end else if ((state == ST_DUMP_END) && ld_fire) begin
      dump_sum <= '0;
    end else if (dump_fire) begin
      dump_sum <= dump_sum + {8'b0, dump_pix};
    end
  end
`endif

endmodule

// File: tb/tb_image_store.sv
// tb_image_store: randomized bench for image_store. It keeps a two-bank image
// model, acts as the processing FSM, and scoreboards the dump stream.
module tb_image_store;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_valid;
  logic [23:0] ld_pix;
  logic        ld_ready;
  logic        proc_start;
  logic [5:0]  row;
  logic [5:0]  col;
  logic [23:0] in_pix;
  logic        out_we;
  logic [23:0] out_pix;
  logic        mirror_done;
  logic        gray_done;
  logic        filter_done;
  logic        dump_valid;
  logic        dump_ready;
  logic [23:0] dump_pix;
  logic        dump_last;
  logic        busy;
  logic [1:0]  dbg_state;
`ifdef STORE_CHECKSUM_EN
  logic [31:0] dump_sum;
`endif

  int checks = 0;
  int errors = 0;

  logic [23:0] exp_q[$];
  logic [23:0] model [0:1][0:4095];
  int          msel;
  int          mon_cnt;
  int          ps_cnt;
  int          drops;
  logic [31:0] exp_sum;
  logic        held_v;
  logic [23:0] held_pix;
  logic        held_last;

  image_store #(.STAGES(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_pix(ld_pix), .ld_ready(ld_ready),
    .proc_start(proc_start),
    .row(row), .col(col), .in_pix(in_pix),
    .out_we(out_we), .out_pix(out_pix),
    .mirror_done(mirror_done), .gray_done(gray_done), .filter_done(filter_done),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_pix(dump_pix), .dump_last(dump_last),
    .busy(busy),
`ifdef STORE_CHECKSUM_EN
    .dump_sum(dump_sum),
`endif
    .dbg_state(dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the expected queue on every dump handshake and checks that
  // a stalled pixel holds until it is taken.
  always @(negedge clk) begin
    logic [23:0] e;
    if (rst_n) begin
      if (proc_start) ps_cnt++;
      if (held_v && dump_valid) begin
        chk("dump_hold_pix", dump_pix, held_pix);
        chk("dump_hold_last", dump_last, held_last);
      end
      held_v = 1'b0;
      if (dump_valid && dump_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dump_extra: got pixel %h expected no pixel", dump_pix);
        end else begin
          e = exp_q.pop_front();
          chk("dump_pix", dump_pix, e);
          chk("dump_last", dump_last, (mon_cnt == 4095));
          exp_sum = exp_sum + {8'b0, e};
        end
        mon_cnt++;
      end else if (dump_valid) begin
        held_v    = 1'b1;
        held_pix  = dump_pix;
        held_last = dump_last;
      end
    end else begin
      held_v = 1'b0;
    end
  end

  // Driver: stream n pixels in raster order (kind 0 = {row,col,12'h0}, else random).
  task automatic load_img(input int n, input int kind, input bit full);
    logic [23:0] v;
    drops   = 0;
    ps_cnt  = 0;
    exp_sum = '0;
    for (int i = 0; i < n; i++) begin
      if (kind == 0) v = {i[11:6], i[5:0], 12'h000};
      else           v = 24'($urandom_range(0, 24'hFFFFFF));
      if (kind != 0 && i == 100) gray_done = 1'b1;
      ld_valid = 1'b1;
      ld_pix   = v;
      @(negedge clk);
      for (int t = 0; t < 8 && !ld_ready; t++) begin
        drops++;
        @(negedge clk);
      end
      tick;
      model[msel][i] = v;
    end
    ld_valid = 1'b0;
    chk("ld_ready_drops", drops, 0);
    if (full) begin
      @(negedge clk);
      chk("proc_start_pulse", proc_start, 1);
      chk("serve_ld_ready", ld_ready, 0);
      tick;
      @(negedge clk);
      chk("proc_start_one_cycle", proc_start, 0);
      chk("proc_start_count", ps_cnt, 1);
      tick;
    end
  endtask

  // Driver: one processing stage writing every pixel, done raised with the last write.
  task automatic run_stage(input int job, input int st);
    logic [23:0] v;
    for (int a = 0; a < 4096; a++) begin
      v = 24'($urandom_range(0, 24'hFFFFFF));
      if (job == 1 && st == 0 && a == 5 * 64 + 9) v = 24'hABCDEF;
      row     = 6'(a >> 6);
      col     = 6'(a & 63);
      out_we  = 1'b1;
      out_pix = v;
      if (a == 4095) begin
        case ({job[1:0], st[1:0]})
          4'b01_00: mirror_done = 1'b1;
          4'b01_01: gray_done   = 1'b1;
          4'b01_10: filter_done = 1'b1;
          4'b10_00: mirror_done = 1'b1;
          4'b10_01: begin gray_done = 1'b1; filter_done = 1'b1; end
          default:  mirror_done = 1'b1;
        endcase
      end
      @(negedge clk);
      chk("in_pix", in_pix, model[msel][a]);
      if (job == 1 && st == 0 && a == 5 * 64 + 9) chk("in_pix_5_9", in_pix, 24'h149000);
      tick;
      model[1 - msel][a] = v;
      if (job == 1 && st == 0 && a == 5 * 64 + 9) begin
        out_we = 1'b0;
        @(negedge clk);
        chk("bank0_5_9_kept", in_pix, 24'h149000);
        tick;
      end
    end
    out_we = 1'b0;
    msel   = 1 - msel;
  endtask

  // Driver: drain the dump stream (mode 0 = ready 1,0,0,1 pattern, else random).
  task automatic run_dump(input int mode);
    int cyc;
    for (int a = 0; a < 4096; a++) exp_q.push_back(model[msel][a]);
    mon_cnt = 0;
    @(negedge clk);
    chk("dump_entered", dump_valid, 1);
    chk("dump_busy", busy, 1);
    tick;
    cyc = 0;
    while (busy && cyc < 20000) begin
      if (mode == 0) dump_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      else           dump_ready = 1'($urandom_range(0, 1));
      if (cyc == 10) begin mirror_done = 0; gray_done = 0; filter_done = 0; end
      if (cyc == 50) mirror_done = 1'b1;
      if (cyc == 60) mirror_done = 1'b0;
      tick;
      cyc++;
    end
    dump_ready = 1'b0;
    if (cyc >= 20000) begin
      checks++;
      errors++;
      $display("FAIL dump_timeout: got %0d handshakes expected 4096", mon_cnt);
    end
    @(negedge clk);
    chk("dump_count", mon_cnt, 4096);
    chk("dump_queue_empty", exp_q.size(), 0);
    chk("end_busy", busy, 0);
    chk("end_dump_valid", dump_valid, 0);
    chk("end_dump_last", dump_last, 0);
    chk("end_ld_ready", ld_ready, 1);
`ifdef STORE_CHECKSUM_EN
    chk("dump_sum", dump_sum, exp_sum);
`endif
    tick;
  endtask

  initial begin
    rst_n = 1'b0; ld_valid = 0; ld_pix = '0; row = '0; col = '0;
    out_we = 0; out_pix = '0; mirror_done = 0; gray_done = 0; filter_done = 0;
    dump_ready = 0; msel = 0; mon_cnt = 0; ps_cnt = 0; exp_sum = '0; held_v = 0;
    #1;
    chk("rst_busy", busy, 1);
    chk("rst_proc_start", proc_start, 0);
    chk("rst_dump_valid", dump_valid, 0);
    chk("rst_dump_last", dump_last, 0);
`ifdef STORE_CHECKSUM_EN
    chk("rst_dump_sum", dump_sum, 0);
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    chk("rel_ld_ready", ld_ready, 1);

    // Job 1: coordinate pattern, held done levels, patterned dump_ready.
    load_img(4096, 0, 1'b1);
    run_stage(1, 0);
    repeat (100) tick;
    @(negedge clk);
    chk("still_serve_1", dump_valid, 0);
    tick;
    run_stage(1, 1);
    @(negedge clk);
    chk("still_serve_2", dump_valid, 0);
    tick;
    run_stage(1, 2);
    run_dump(0);

    // Abort a load at ld_cnt=2000 with an asynchronous reset.
    load_img(2000, 1, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 1);
    chk("arst_ld_ready", ld_ready, 1);
    chk("arst_proc_start", proc_start, 0);
    chk("arst_dump_valid", dump_valid, 0);
    msel = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick;

    // Job 2: done edges outside SERVE, simultaneous edges, random dump_ready.
    load_img(4096, 1, 1'b1);
    run_stage(2, 0);
    mirror_done = 0; gray_done = 0;
    run_stage(2, 1);
    gray_done = 0; filter_done = 0;
    run_stage(2, 2);
    run_dump(1);

    // Asynchronous reset from DUMP_END must raise busy without a clock edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_end_busy", busy, 1);
`ifdef STORE_CHECKSUM_EN
    chk("arst_dump_sum", dump_sum, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
